ul_div_req_sched: RTL and testbench
===================================

# ul_div_req_sched

Request scheduler that sits directly upstream of the uplink multi-cycle sequential divider. It queues tagged division requests from several uplink producers, such as DMRS index and PRB modulo computations. It issues them one at a time to the divider with a single-cycle start pulse, then returns quotient, remainder and tag on a valid/ready response port. It serialises access to the single shared divider instance and absorbs the divider's multi-cycle latency.

## Interface
- DIVIDEND_WIDTH, 22, dividend and quotient width
- DIVISOR_WIDTH, 11, divisor and remainder width
- TAG_WIDTH, 4, opaque request tag returned with the result
- DEPTH, 4, request queue entries (power of two, ≥2)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid / req_ready  in / out  1  request handshake; transfer when both high
- req_dividend / req_divisor / req_tag  in  DIVIDEND_WIDTH / DIVISOR_WIDTH / TAG_WIDTH  request payload
- div_start  out  1  one-cycle start pulse to the divider
- div_dividend / div_divisor  out  DIVIDEND_WIDTH / DIVISOR_WIDTH  operands, held stable from start until done
- div_busy / div_done  in  1  divider status and one-cycle completion pulse
- div_quotient / div_remainder  in  DIVIDEND_WIDTH / DIVISOR_WIDTH  divider result, valid in the div_done cycle
- rsp_valid / rsp_ready  out / in  1  response handshake
- rsp_quotient / rsp_remainder / rsp_tag  out  DIVIDEND_WIDTH / DIVISOR_WIDTH / TAG_WIDTH  response payload
- rsp_err  out  1  divisor was zero (only when the zero check is compiled in, else 0)
- q_level  out  $clog2(DEPTH)+1  current queue occupancy

## Operation
- **Queue:** synchronous FIFO of {dividend, divisor, tag}.
  - req_ready = ~full.
  - Push on req_valid & req_ready.
  - Pop only in the ISSUE state.
  - Push and pop in the same cycle leave q_level unchanged.
  - Full with a simultaneous pop: req_ready remains 0 that cycle. There is no same-cycle bypass.
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
  - IDLE → ISSUE when queue non-empty and div_busy = 0.
  - ISSUE, one cycle: div_start = 1; the FIFO head is latched into the operand and tag registers; pop. → WAIT.
  - WAIT: on div_done, capture div_quotient/div_remainder into the response registers. → RESP.
  - RESP: rsp_valid = 1, payload stable. On rsp_ready → IDLE.
- Only one request is outstanding at a time. Responses come back in request order.
- div_done is ignored outside WAIT.
- div_dividend/div_divisor stay constant from the ISSUE cycle through the div_done cycle.
- **Reset values:** all outputs 0, state IDLE, queue empty. req_ready becomes 1 in the first cycle after reset release.
- **Reset mid-operation:** the request in flight and all queued entries are discarded. No response is produced. div_start goes 0 immediately.

## Timing
- Push at edge E0 → queue non-empty from E0 → FSM enters ISSUE at E1 → div_start high in cycle E1–E2.
- div_done in cycle D → rsp_valid high from the next edge.
- Minimum overhead around the divider: 2 cycles before start and 1 cycle after done.
- With rsp_ready tied high, back-to-back requests are spaced by the divider latency + 3 cycles.
- The FSM remains in RESP indefinitely while rsp_ready = 0. The queue keeps accepting requests until it is full.

## Configuration
- **UL_DIV_ZERO_CHK_EN defined:** in IDLE, a head entry with divisor = 0 bypasses the divider.
  - The FSM goes IDLE → RESP directly and pops the entry; no div_start is issued.
  - Response: rsp_err = 1, quotient all ones, remainder = dividend[DIVISOR_WIDTH-1:0].
  - The bypass is taken even when div_busy = 1.
- **Not defined:** zero divisors are issued to the divider like any other request. rsp_err is tied to 0.

## Structure
- Package ul_div_pkg holds:
  - FSM state enum
  - default width constants (22/11/4)
  - all-ones quotient constant for the error response
- Sub-module ul_sync_fifo: parameterised width/depth synchronous FIFO with full, empty and level outputs. The FSM and response registers stay in the top module.

## Test plan
Bench uses a behavioural divider model: busy for 23 cycles after start, done pulse on the last cycle, exact integer results.
- Single request 1000/7, tag 3 → one div_start, response q=142, r=6, tag 3, rsp_err 0.
- Five requests pushed back to back with DEPTH=4 → req_ready low after 4 pushes. All five are answered in order with correct tags.
- rsp_ready held low for 50 cycles during RESP → payload stable, no further div_start, queue fills, req_ready drops.
- Divisor 0, dividend 0x3FFFFF, with UL_DIV_ZERO_CHK_EN → no div_start, rsp_err 1, q=0x3FFFFF, r=0x7FF. Without the macro → div_start issued, rsp_err 0.
- rst_n asserted in WAIT with 2 entries queued → all outputs 0 next cycle. After release, no response is produced and q_level = 0.
- div_busy forced high externally in IDLE with a non-empty queue → no div_start until div_busy falls. Then the request is issued within 1 cycle.

Source files
------------

// File: rtl/ul_div_pkg.sv
// -----------------------------------------------------------------------------
// ul_div_pkg
// Shared definitions for the uplink divider request scheduler:
//   - default payload widths and queue depth
//   - all-ones quotient returned for a zero-divisor error response
//   - scheduler FSM state encoding
// -----------------------------------------------------------------------------
package ul_div_pkg;

   localparam int DIVIDEND_WIDTH_D = 22;
   localparam int DIVISOR_WIDTH_D  = 11;
   localparam int TAG_WIDTH_D      = 4;
   localparam int DEPTH_D          = 4;

   // Signed so that a size cast to a wider quotient still yields all ones.
   localparam logic signed [DIVIDEND_WIDTH_D-1:0] QUOT_ERR = '1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } sched_state_t;

endpackage

// File: rtl/ul_div_req_sched_if.sv
// -----------------------------------------------------------------------------
// ul_div_req_sched_if
// Bundles the three ports of the divider request scheduler:
//   req_*  : request push port (valid/ready), payload dividend/divisor/tag
//   div_*  : start/operands towards the divider, busy/done/results back
//   rsp_*  : response port (valid/ready), quotient/remainder/tag/err
//   q_level: request queue occupancy
// Handshake rule for req and rsp: a transfer happens on a rising clock edge
// where valid and ready are both high; the producer holds valid and payload
// stable until that edge, and ready may depend on nothing the producer drives.
// Modports:
//   slave  : the scheduler's view
//   master : the environment's view (producers, divider, response consumer)
// -----------------------------------------------------------------------------
interface ul_div_req_sched_if
   import ul_div_pkg::*;
#(
   parameter int DIVIDEND_WIDTH = DIVIDEND_WIDTH_D,
   parameter int DIVISOR_WIDTH  = DIVISOR_WIDTH_D,
   parameter int TAG_WIDTH      = TAG_WIDTH_D,
   parameter int DEPTH          = DEPTH_D
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic                      req_valid;
   logic                      req_ready;
   logic [DIVIDEND_WIDTH-1:0] req_dividend;
   logic [DIVISOR_WIDTH-1:0]  req_divisor;
   logic [TAG_WIDTH-1:0]      req_tag;

   logic                      div_start;
   logic [DIVIDEND_WIDTH-1:0] div_dividend;
   logic [DIVISOR_WIDTH-1:0]  div_divisor;
   logic                      div_busy;
   logic                      div_done;
   logic [DIVIDEND_WIDTH-1:0] div_quotient;
   logic [DIVISOR_WIDTH-1:0]  div_remainder;

   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [DIVIDEND_WIDTH-1:0] rsp_quotient;
   logic [DIVISOR_WIDTH-1:0]  rsp_remainder;
   logic [TAG_WIDTH-1:0]      rsp_tag;
   logic                      rsp_err;

   logic [LW-1:0]             q_level;

   modport slave (
      input  req_valid, req_dividend, req_divisor, req_tag,
      output req_ready,
      output div_start, div_dividend, div_divisor,
      input  div_busy, div_done, div_quotient, div_remainder,
      output rsp_valid, rsp_quotient, rsp_remainder, rsp_tag, rsp_err,
      input  rsp_ready,
      output q_level
   );

   modport master (
      output req_valid, req_dividend, req_divisor, req_tag,
      input  req_ready,
      input  div_start, div_dividend, div_divisor,
      output div_busy, div_done, div_quotient, div_remainder,
      input  rsp_valid, rsp_quotient, rsp_remainder, rsp_tag, rsp_err,
      output rsp_ready,
      input  q_level
   );

endinterface

// File: rtl/ul_sync_fifo.sv
// -----------------------------------------------------------------------------
// ul_sync_fifo
// Single-clock FIFO, DEPTH a power of two. Head is presented combinationally
// on o_rdata whenever the FIFO is non-empty (show-ahead).
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_push, i_wdata   : write request and data (ignored when full)
//   i_pop             : remove head (ignored when empty)
//   o_rdata           : current head entry
//   o_full, o_empty   : status
//   o_level           : occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module ul_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_level == (AW+1)'(DEPTH));
   assign o_empty   = (r_level == '0);
   assign o_level   = r_level;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/ul_div_req_sched.sv
// -----------------------------------------------------------------------------
// ul_div_req_sched
// Queues tagged division requests and feeds them one at a time to a shared
// multi-cycle divider, returning quotient/remainder/tag on a response port.
// Only one request is outstanding, so responses leave in request order.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus (slave)  : req_* push port, div_* divider port, rsp_* response port,
//                  q_level queue occupancy
//   o_dbg_state  : current FSM state
// Build option:
//   UL_DIV_ZERO_CHK_EN - a head entry with divisor 0 skips the divider and is
//   answered directly with rsp_err=1, all-ones quotient and the low dividend
//   bits as remainder. Without it, rsp_err is constant 0 and zero divisors go
//   to the divider like any other request.
// -----------------------------------------------------------------------------
module ul_div_req_sched
   import ul_div_pkg::*;
#(
   parameter int DIVIDEND_WIDTH = DIVIDEND_WIDTH_D,
   parameter int DIVISOR_WIDTH  = DIVISOR_WIDTH_D,
   parameter int TAG_WIDTH      = TAG_WIDTH_D,
   parameter int DEPTH          = DEPTH_D
) (
   input  logic                clk,
   input  logic                rst_n,
   ul_div_req_sched_if.slave   bus,
   output sched_state_t        o_dbg_state
);
   localparam int PW = DIVIDEND_WIDTH + DIVISOR_WIDTH + TAG_WIDTH;
   localparam int LW = $clog2(DEPTH) + 1;

   logic [PW-1:0]             w_head;
   logic [DIVIDEND_WIDTH-1:0] w_head_dividend;
   logic [DIVISOR_WIDTH-1:0]  w_head_divisor;
   logic [TAG_WIDTH-1:0]      w_head_tag;
   logic                      w_full;
   logic                      w_empty;
   logic [LW-1:0]             w_level;
   logic                      w_push;
   logic                      w_pop;
   logic                      w_zero_bypass;

   sched_state_t              r_state;
   logic                      r_run;
   logic                      r_div_start;
   logic [DIVIDEND_WIDTH-1:0] r_div_dividend;
   logic [DIVISOR_WIDTH-1:0]  r_div_divisor;
   logic [TAG_WIDTH-1:0]      r_tag;
   logic                      r_rsp_valid;
   logic [DIVIDEND_WIDTH-1:0] r_rsp_quot;
   logic [DIVISOR_WIDTH-1:0]  r_rsp_rem;
   logic [TAG_WIDTH-1:0]      r_rsp_tag;
   logic                      r_rsp_err;

   // r_run keeps req_ready low while in reset and rises on the first edge
   // after release.
   assign bus.req_ready = r_run & ~w_full;
   assign w_push        = bus.req_valid & bus.req_ready;
   assign {w_head_dividend, w_head_divisor, w_head_tag} = w_head;

`ifdef UL_DIV_ZERO_CHK_EN
   // Checked ahead of div_busy: an error answer never needs the divider.
   assign w_zero_bypass = (r_state == ST_IDLE) & ~w_empty & (w_head_divisor == '0);
`else
   assign w_zero_bypass = 1'b0;
`endif

   // Head is latched on the IDLE->ISSUE edge and removed during ISSUE.
   assign w_pop = (r_state == ST_ISSUE) | w_zero_bypass;

   ul_sync_fifo #(
      .WIDTH (PW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_wdata ({bus.req_dividend, bus.req_divisor, bus.req_tag}),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_IDLE;
         r_run          <= 1'b0;
         r_div_start    <= 1'b0;
         r_div_dividend <= '0;
         r_div_divisor  <= '0;
         r_tag          <= '0;
         r_rsp_valid    <= 1'b0;
         r_rsp_quot     <= '0;
         r_rsp_rem      <= '0;
         r_rsp_tag      <= '0;
         r_rsp_err      <= 1'b0;
      end else begin
         r_run       <= 1'b1;
         r_div_start <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_zero_bypass) begin
                  r_rsp_quot  <= DIVIDEND_WIDTH'(QUOT_ERR);
                  r_rsp_rem   <= w_head_dividend[DIVISOR_WIDTH-1:0];
                  r_rsp_tag   <= w_head_tag;
                  r_rsp_err   <= 1'b1;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_RESP;
               end else if (!w_empty && !bus.div_busy) begin
                  // Operands are registered here so they are already valid
                  // alongside the start pulse and stay put until the next issue.
                  r_div_start    <= 1'b1;
                  r_div_dividend <= w_head_dividend;
                  r_div_divisor  <= w_head_divisor;
                  r_tag          <= w_head_tag;
                  r_state        <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (bus.div_done) begin
                  r_rsp_quot  <= bus.div_quotient;
                  r_rsp_rem   <= bus.div_remainder;
                  r_rsp_tag   <= r_tag;
                  r_rsp_err   <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.div_start     = r_div_start;
   assign bus.div_dividend  = r_div_dividend;
   assign bus.div_divisor   = r_div_divisor;
   assign bus.rsp_valid     = r_rsp_valid;
   assign bus.rsp_quotient  = r_rsp_quot;
   assign bus.rsp_remainder = r_rsp_rem;
   assign bus.rsp_tag       = r_rsp_tag;
`ifdef UL_DIV_ZERO_CHK_EN
   assign bus.rsp_err       = r_rsp_err;
`else
   assign bus.rsp_err       = 1'b0;
`endif
   assign bus.q_level       = w_level;
   assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_ul_div_req_sched.sv
`timescale 1ns/1ps
module tb_ul_div_req_sched;
   import ul_div_pkg::*;

   localparam int DW    = 22;
   localparam int VW    = 11;
   localparam int TW    = 4;
   localparam int DEPTH = 4;
   localparam int LAT   = 23;
   localparam int RW    = 1 + TW + VW + DW;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   ul_div_req_sched_if #(
      .DIVIDEND_WIDTH (DW),
      .DIVISOR_WIDTH  (VW),
      .TAG_WIDTH      (TW),
      .DEPTH          (DEPTH)
   ) bus ();

   sched_state_t dbg_state;

   ul_div_req_sched #(
      .DIVIDEND_WIDTH (DW),
      .DIVISOR_WIDTH  (VW),
      .TAG_WIDTH      (TW),
      .DEPTH          (DEPTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // ---------------- behavioural divider ----------------
   // Busy for LAT cycles after a start, done on the last one; results are
   // taken from the operands presented at done time.
   int   div_cnt;
   logic force_busy;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             div_cnt <= 0;
      else if (bus.div_start && div_cnt == 0) div_cnt <= LAT;
      else if (div_cnt != 0)                  div_cnt <= div_cnt - 1;
   end

   assign bus.div_busy      = (div_cnt != 0) | force_busy;
   assign bus.div_done      = (div_cnt == 1);
   assign bus.div_quotient  = !bus.div_done ? '0 :
                              (bus.div_divisor == '0) ? '1 : bus.div_dividend / DW'(bus.div_divisor);
   assign bus.div_remainder = !bus.div_done ? '0 :
                              (bus.div_divisor == '0) ? bus.div_dividend[VW-1:0] :
                              VW'(bus.div_dividend % DW'(bus.div_divisor));

   // ---------------- reference model ----------------
   function automatic logic [RW-1:0] ref_rsp(input logic [DW-1:0] a, input logic [VW-1:0] b,
                                             input logic [TW-1:0] t);
      logic [DW-1:0] q;
      logic [VW-1:0] r;
      logic          e;
      if (b == '0) begin
         q = '1;
         r = a[VW-1:0];
`ifdef UL_DIV_ZERO_CHK_EN
         e = 1'b1;
`else
         e = 1'b0;
`endif
      end else begin
         q = a / DW'(b);
         r = VW'(a % DW'(b));
         e = 1'b0;
      end
      return {e, t, r, q};
   endfunction

   // ---------------- scoreboard / monitors ----------------
   logic [RW-1:0] exp_q[$];
   logic [RW-1:0] got_q[$];
   int            start_cyc_q[$];
   int            push_cyc_q[$];
   int            got_cyc_q[$];
   logic          op_hold;
   logic          op_unstable;
   logic [DW-1:0] op_a;
   logic [VW-1:0] op_b;

   int n_err    = 0;
   int n_checks = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         op_hold <= 1'b0;
      end else begin
         if (bus.req_valid && bus.req_ready) begin
            exp_q.push_back(ref_rsp(bus.req_dividend, bus.req_divisor, bus.req_tag));
            push_cyc_q.push_back(cyc);
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            got_q.push_back({bus.rsp_err, bus.rsp_tag, bus.rsp_remainder, bus.rsp_quotient});
            got_cyc_q.push_back(cyc);
         end
         if (bus.div_start) begin
            start_cyc_q.push_back(cyc);
            op_hold <= 1'b1;
            op_a    <= bus.div_dividend;
            op_b    <= bus.div_divisor;
         end else begin
            if (op_hold && (bus.div_dividend !== op_a || bus.div_divisor !== op_b))
               op_unstable <= 1'b1;
            if (bus.div_done) op_hold <= 1'b0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   // All tasks start and end just after a rising edge.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_req(input logic [DW-1:0] a, input logic [VW-1:0] b,
                           input logic [TW-1:0] t, input int budget, output bit ok);
      bus.req_valid    = 1'b1;
      bus.req_dividend = a;
      bus.req_divisor  = b;
      bus.req_tag      = t;
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         ok = bus.req_ready;
         @(posedge clk);
         #1;
      end
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_rsps(input int n, input int budget, output bit ok);
      for (int i = 0; i < budget && got_q.size() < n; i++) tick(1);
      ok = (got_q.size() >= n);
   endtask

   task automatic clear_logs();
      exp_q.delete();
      got_q.delete();
      start_cyc_q.delete();
      push_cyc_q.delete();
      got_cyc_q.delete();
   endtask

   function automatic logic [DW-1:0] rnd_dividend();
      return DW'($urandom_range(0, (1 << DW) - 1));
   endfunction

   function automatic logic [VW-1:0] rnd_divisor();
      return VW'($urandom_range(1, (1 << VW) - 1));
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [76:0] outs;
      @(negedge clk);
      outs = {bus.req_ready, bus.div_start, bus.div_dividend, bus.div_divisor, bus.rsp_valid,
              bus.rsp_quotient, bus.rsp_remainder, bus.rsp_tag, bus.rsp_err, bus.q_level};
      n_checks++;
      if (outs !== '0) begin
         n_err++;
         $display("FAIL reset_outputs got=%h exp=0", outs);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick(1);
      @(negedge clk);
      n_checks++;
      if (bus.req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready);
      end
      n_checks++;
      if (bus.q_level !== '0 || bus.rsp_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_idle q_level=%0d rsp_valid=%b exp 0/0", bus.q_level, bus.rsp_valid);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_single();
      bit ok;
      logic [RW-1:0] want;
      clear_logs();
      bus.rsp_ready = 1'b1;
      push_req(22'd1000, 11'd7, 4'd3, 5, ok);
      wait_rsps(1, 60, ok);
      want = {1'b0, 4'd3, 11'd6, 22'd142};
      n_checks++;
      if (!ok || got_q[0] !== want) begin
         n_err++;
         $display("FAIL single_rsp got=%h exp=%h", ok ? got_q[0] : 'x, want);
      end
      n_checks++;
      if (start_cyc_q.size() != 1) begin
         n_err++;
         $display("FAIL single_start_count got=%0d exp=1", start_cyc_q.size());
      end else begin
         n_checks++;
         if (start_cyc_q[0] - push_cyc_q[0] != 2) begin
            n_err++;
            $display("FAIL single_issue_latency got=%0d exp=2", start_cyc_q[0] - push_cyc_q[0]);
         end
         n_checks++;
         if (ok && got_cyc_q[0] - start_cyc_q[0] != LAT + 1) begin
            n_err++;
            $display("FAIL single_rsp_latency got=%0d exp=%0d", got_cyc_q[0] - start_cyc_q[0], LAT + 1);
         end
      end
      tick(3);
   endtask

   task automatic test_busy_hold();
      bit ok;
      int f;
      clear_logs();
      bus.rsp_ready = 1'b1;
      force_busy = 1'b1;
      push_req(rnd_dividend(), rnd_divisor(), 4'd5, 5, ok);
      tick(10);
      n_checks++;
      if (start_cyc_q.size() != 0 || bus.q_level !== 3'd1) begin
         n_err++;
         $display("FAIL busy_hold starts=%0d q_level=%0d exp 0/1", start_cyc_q.size(), bus.q_level);
      end
      force_busy = 1'b0;
      f = cyc;
      tick(4);
      n_checks++;
      if (start_cyc_q.size() != 1 || start_cyc_q[0] - f != 1) begin
         n_err++;
         $display("FAIL busy_release_issue starts=%0d delay=%0d exp 1/1", start_cyc_q.size(),
                  start_cyc_q.size() > 0 ? start_cyc_q[0] - f : -1);
      end
      wait_rsps(1, 60, ok);
      n_checks++;
      if (!ok || got_q[0] !== exp_q[0]) begin
         n_err++;
         $display("FAIL busy_rsp got=%h exp=%h", ok ? got_q[0] : 'x, exp_q[0]);
      end
      tick(3);
   endtask

   task automatic test_back_to_back();
      bit ok;
      logic [RW-1:0] got;
      logic [DW-1:0] a5;
      logic [VW-1:0] b5;
      clear_logs();
      op_unstable = 1'b0;
      bus.rsp_ready = 1'b1;
      force_busy = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         push_req(rnd_dividend(), rnd_divisor(), TW'(i + 8), 5, ok);
         n_checks++;
         if (!ok) begin
            n_err++;
            $display("FAIL b2b_push%0d got=refused exp=accepted", i);
         end
      end
      a5 = rnd_dividend();
      b5 = rnd_divisor();
      push_req(a5, b5, 4'd12, 3, ok);
      n_checks++;
      if (ok || bus.q_level !== 3'd4) begin
         n_err++;
         $display("FAIL b2b_full accepted=%b q_level=%0d exp 0/4", ok, bus.q_level);
      end
      force_busy = 1'b0;
      push_req(a5, b5, 4'd12, 10, ok);
      wait_rsps(5, 5 * (LAT + 4) + 20, ok);
      n_checks++;
      if (exp_q.size() != 5) begin
         n_err++;
         $display("FAIL b2b_accepted got=%0d exp=5", exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < got_q.size()) ? got_q[i] : 'x;
         n_checks++;
         if (got !== exp_q[i]) begin
            n_err++;
            $display("FAIL b2b_rsp%0d got=%h exp=%h", i, got, exp_q[i]);
         end
      end
      for (int i = 1; i < start_cyc_q.size(); i++) begin
         n_checks++;
         if (start_cyc_q[i] - start_cyc_q[i-1] != LAT + 3) begin
            n_err++;
            $display("FAIL b2b_spacing%0d got=%0d exp=%0d", i, start_cyc_q[i] - start_cyc_q[i-1], LAT + 3);
         end
      end
      n_checks++;
      if (op_unstable !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_operand_stability got=changed exp=stable");
      end
      tick(3);
   endtask

   task automatic test_rsp_stall();
      bit ok;
      bit stable;
      int n_start;
      logic [RW-1:0] snap;
      logic [RW-1:0] got;
      clear_logs();
      bus.rsp_ready = 1'b0;
      push_req(rnd_dividend(), rnd_divisor(), 4'd1, 5, ok);
      for (int i = 0; i < 60 && !bus.rsp_valid; i++) tick(1);
      n_checks++;
      if (bus.rsp_valid !== 1'b1) begin
         n_err++;
         $display("FAIL stall_rsp_valid got=%b exp=1", bus.rsp_valid);
      end
      snap = {bus.rsp_err, bus.rsp_tag, bus.rsp_remainder, bus.rsp_quotient};
      n_start = start_cyc_q.size();
      stable = 1'b1;
      for (int i = 0; i < DEPTH; i++) push_req(rnd_dividend(), rnd_divisor(), TW'(i + 2), 5, ok);
      for (int i = 0; i < 50 - DEPTH; i++) begin
         @(negedge clk);
         if (bus.rsp_valid !== 1'b1 ||
             {bus.rsp_err, bus.rsp_tag, bus.rsp_remainder, bus.rsp_quotient} !== snap)
            stable = 1'b0;
         @(posedge clk);
         #1;
      end
      n_checks++;
      if (!stable) begin
         n_err++;
         $display("FAIL stall_payload got=changed exp=stable");
      end
      n_checks++;
      if (start_cyc_q.size() != n_start) begin
         n_err++;
         $display("FAIL stall_no_start got=%0d exp=%0d", start_cyc_q.size(), n_start);
      end
      n_checks++;
      if (bus.req_ready !== 1'b0 || bus.q_level !== 3'd4) begin
         n_err++;
         $display("FAIL stall_queue_full req_ready=%b q_level=%0d exp 0/4", bus.req_ready, bus.q_level);
      end
      bus.rsp_ready = 1'b1;
      wait_rsps(5, 5 * (LAT + 4) + 20, ok);
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < got_q.size()) ? got_q[i] : 'x;
         n_checks++;
         if (got !== exp_q[i]) begin
            n_err++;
            $display("FAIL stall_rsp%0d got=%h exp=%h", i, got, exp_q[i]);
         end
      end
      tick(3);
   endtask

   task automatic test_zero_div();
      bit ok;
      logic [RW-1:0] want;
      clear_logs();
      bus.rsp_ready = 1'b1;
`ifdef UL_DIV_ZERO_CHK_EN
      force_busy = 1'b1;
      want = {1'b1, 4'd9, 11'h7FF, 22'h3FFFFF};
`else
      want = {1'b0, 4'd9, 11'h7FF, 22'h3FFFFF};
`endif
      push_req(22'h3FFFFF, 11'd0, 4'd9, 5, ok);
      wait_rsps(1, 60, ok);
      n_checks++;
      if (!ok || got_q[0] !== want) begin
         n_err++;
         $display("FAIL zero_rsp got=%h exp=%h", ok ? got_q[0] : 'x, want);
      end
      n_checks++;
`ifdef UL_DIV_ZERO_CHK_EN
      if (start_cyc_q.size() != 0) begin
         n_err++;
         $display("FAIL zero_start_count got=%0d exp=0", start_cyc_q.size());
      end
`else
      if (start_cyc_q.size() != 1) begin
         n_err++;
         $display("FAIL zero_start_count got=%0d exp=1", start_cyc_q.size());
      end
`endif
      force_busy = 1'b0;
      tick(3);
   endtask

   task automatic test_reset_mid();
      bit ok;
      logic [76:0] outs;
      clear_logs();
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 3; i++) push_req(rnd_dividend() | 22'h1, rnd_divisor(), TW'(i), 5, ok);
      for (int i = 0; i < 20 && start_cyc_q.size() == 0; i++) tick(1);
      tick(5);
      n_checks++;
      if (dbg_state !== ST_WAIT || bus.q_level !== 3'd2) begin
         n_err++;
         $display("FAIL mid_setup state=%0d q_level=%0d exp WAIT/2", dbg_state, bus.q_level);
      end
      rst_n = 1'b0;
      @(negedge clk);
      outs = {bus.req_ready, bus.div_start, bus.div_dividend, bus.div_divisor, bus.rsp_valid,
              bus.rsp_quotient, bus.rsp_remainder, bus.rsp_tag, bus.rsp_err, bus.q_level};
      n_checks++;
      if (outs !== '0) begin
         n_err++;
         $display("FAIL mid_reset_outputs got=%h exp=0", outs);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_logs();
      tick(60);
      n_checks++;
      if (got_q.size() != 0 || start_cyc_q.size() != 0) begin
         n_err++;
         $display("FAIL mid_discard rsps=%0d starts=%0d exp 0/0", got_q.size(), start_cyc_q.size());
      end
      n_checks++;
      if (bus.q_level !== '0 || bus.req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL mid_after_release q_level=%0d req_ready=%b exp 0/1", bus.q_level, bus.req_ready);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      bus.req_valid    = 1'b0;
      bus.req_dividend = '0;
      bus.req_divisor  = '0;
      bus.req_tag      = '0;
      bus.rsp_ready    = 1'b0;
      force_busy       = 1'b0;
      op_unstable      = 1'b0;
      tick(3);
      test_reset();
      test_single();
      test_busy_hold();
      test_back_to_back();
      test_rsp_stall();
      test_zero_div();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
